// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, BCD decode and conversion FSM encoding
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [31:0] max_decimal(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd.sv
// rtl/seg7_scan_display_bin2bcd.sv - sequential double-dabble, one bit per cycle
module bin2bcd_seq #(
  parameter int VAL_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VAL_W-1:0]        bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CW'(VAL_W);
    end else if (cnt_q != '0) begin
      // Carries out of the top nibble are dropped; the top flags overflow separately.
      bcd_d = {adj[BW-2:0], sh_q[VAL_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - load/busy BCD conversion and multiplexed N-digit 7-seg scan
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int VAL_W        = 14,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [VAL_W-1:0]      value,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0] MAX_VAL = max_decimal(NUM_DIGITS);

  conv_state_e             state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    overflow_q, overflow_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    blink_on_q, blink_on_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic                    conv_start, conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic [6:0]              pat;

  assign conv_start = (state_q == IDLE) && load;

  bin2bcd_seq #(
    .VAL_W      (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (value),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    digits_d   = digits_q;
    case (state_q)
      IDLE: if (load) begin
        state_d    = CONV;
        ovf_pend_d = 32'(value) > MAX_VAL;
      end
      CONV:   if (conv_done) state_d = COMMIT;
      COMMIT: begin
        state_d    = IDLE;
        digits_d   = conv_bcd;
        overflow_d = ovf_pend_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run && (digits_q[4*i +: 4] == 4'd0);
      lz_mask[i] = lz_run;
    end
    lz_mask[0] = 1'b0;
  end

  always_comb begin
    presc_d    = presc_q + PW'(1);
    idx_d      = idx_q;
    frame_d    = frame_q;
    blink_on_d = blink_on_q;
    seg_d      = seg_q;
    dig_sel_d  = dig_sel_q;
    pat        = SEG_BLANK;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_d    = '0;
          blink_on_d = !blink_on_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
      if (overflow_q)                       pat = SEG_DASH;
      else if (blank_lz && lz_mask[idx_d])  pat = SEG_BLANK;
      else                                  pat = bcd_to_seg(digits_q[4*idx_d +: 4]);
      if (blink_en[idx_d] && !blink_on_d)   pat = SEG_BLANK;
      seg_d     = pat;
      dig_sel_d = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      blink_on_q <= 1'b1;
      seg_q      <= SEG_0;
      dig_sel_q  <= NUM_DIGITS'(1);
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      blink_on_q <= blink_on_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign dig_sel  = dig_sel_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - directed self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [13:0] value;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [6:0] cap [4];
  logic [6:0] s2 [8];
  int         cyc;

  seg7_scan_display #(
    .NUM_DIGITS   (4),
    .VAL_W        (14),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .dig_sel  (dig_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic align();
    int n = 0;
    while (dig_sel !== 4'b1000 && n < 100) begin @(negedge clk); n++; end
    while (dig_sel !== 4'b0001 && n < 100) begin @(negedge clk); n++; end
    check("align", 32'(n < 100), 32'd1);
  endtask

  task automatic capture_frame();
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) if (dig_sel === (4'b0001 << i)) cap[i] = seg;
      @(negedge clk);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    align();
    capture_frame();
    check({tag, "_d3"}, 32'(cap[3]), 32'(e3));
    check({tag, "_d2"}, 32'(cap[2]), 32'(e2));
    check({tag, "_d1"}, 32'(cap[1]), 32'(e1));
    check({tag, "_d0"}, 32'(cap[0]), 32'(e0));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic do_load(input logic [13:0] v, output int n);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0; blink_en = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dig_sel", 32'(dig_sel), 32'b0001);
    check("rst_seg", 32'(seg), 32'b0111111);
    check_digits("idle_nolz", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    blank_lz = 1'b1;
    check_digits("idle_lz", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);

    do_load(14'd125, cyc);
    check("busy_len_125", 32'(cyc), 32'd15);
    check_digits("v125_lz", 7'b0000000, 7'b0000110, 7'b1011011, 7'b1101101);
    blank_lz = 1'b0;
    check_digits("v125_nolz", 7'b0111111, 7'b0000110, 7'b1011011, 7'b1101101);

    blank_lz = 1'b1;
    do_load(14'd10000, cyc);
    check("ovf_set", 32'(overflow), 32'd1);
    check_digits("v10000", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    do_load(14'd0, cyc);
    check("ovf_clr", 32'(overflow), 32'd0);
    check_digits("v0_lz", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);

    blank_lz = 1'b0;
    load = 1'b1; value = 14'd160;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    load = 1'b1; value = 14'd9999;
    @(negedge clk);
    load = 1'b0;
    wait_idle(cyc);
    check("busy_len_160", 32'(cyc), 32'd12);
    repeat (5) @(negedge clk);
    check("dropped_no_busy", 32'(busy), 32'd0);
    check_digits("v160", 7'b0111111, 7'b0000110, 7'b1111101, 7'b0111111);

    load = 1'b1; value = 14'd42;
    @(negedge clk);
    wait_idle(cyc);
    check("b2b_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_retrig", 32'(busy), 32'd1);
    load = 1'b0;
    wait_idle(cyc);

    blink_en = 4'b0100;
    do_load(14'd8888, cyc);
    align();
    for (int f = 0; f < 8; f++) begin
      capture_frame();
      s2[f] = cap[2];
      check("blink_d3", 32'(cap[3]), 32'b1111111);
      check("blink_d0", 32'(cap[0]), 32'b1111111);
      check("blink_d2_val", 32'(cap[2] === 7'b1111111 || cap[2] === 7'b0000000), 32'd1);
    end
    for (int f = 0; f < 6; f++) check("blink_period", 32'(s2[f+2] !== s2[f]), 32'd1);

    blink_en = '0;
    load = 1'b1; value = 14'd145;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dig_sel", 32'(dig_sel), 32'b0001);
    check("abort_seg", 32'(seg), 32'b0111111);
    repeat (20) @(negedge clk);
    check("abort_busy_late", 32'(busy), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check_digits("abort", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
